// File: rtl/hazard_ctrl.sv
// Pipeline hazard/trap sequencer: load-use stall, memory-wait stall/timeout, branch/MRET/trap flush+redirect.
// Optional HAZARD_PERF_EN adds stall-cycle and redirect counters (ports tied to 0 otherwise).

`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif
`ifndef ILLEGAL
`define ILLEGAL 0
`endif
`ifndef ECALL
`define ECALL 1
`endif
`ifndef EBREAK
`define EBREAK 2
`endif
`ifndef MRET
`define MRET 3
`endif

module hazard_ctrl #(
    parameter int                    AWIDTH       = 5,
    parameter int                    PC_WIDTH     = 32,
    parameter int                    FLUSH_CYCLES = 2,
    parameter logic [PC_WIDTH-1:0]   TRAP_VECTOR  = 32'h0000_0100,
    parameter int                    MAX_MEM_WAIT = 15
) (
    input  logic                         h_clk,
    input  logic                         h_rst,
    input  logic [AWIDTH-1:0]            h_i_de_rs1,
    input  logic [AWIDTH-1:0]            h_i_de_rs2,
    input  logic                         h_i_ex_ce,
    input  logic [AWIDTH-1:0]            h_i_ex_rd,
    input  logic                         h_i_ex_load,
    input  logic                         h_i_ex_taken,
    input  logic [PC_WIDTH-1:0]          h_i_ex_target,
    input  logic [PC_WIDTH-1:0]          h_i_ex_pc,
    input  logic [`EXCEPTION_WIDTH-1:0]  h_i_ex_exception,
    input  logic                         h_i_mem_busy,
    output logic                         h_o_stall,
    output logic                         h_o_bubble,
    output logic                         h_o_flush,
    output logic                         h_o_redirect,
    output logic [PC_WIDTH-1:0]          h_o_redirect_pc,
    output logic [PC_WIDTH-1:0]          h_o_mepc,
    output logic [1:0]                   h_o_mcause,
    output logic [1:0]                   h_o_state,
    output logic                         h_o_halt,
    output logic [31:0]                  h_o_stall_cnt,
    output logic [31:0]                  h_o_flush_cnt
);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_TRAP = 2'd2, ST_HALT = 2'd3} state_t;

    state_t                state, state_nxt;
    logic [3:0]            fcnt, fcnt_nxt;
    logic [7:0]            wcnt, wcnt_nxt, wcnt_inc;
    logic                  flush_nxt, redir_nxt;
    logic [PC_WIDTH-1:0]   redir_pc_nxt, mepc_nxt;
    logic [1:0]            mcause_nxt;
    logic                  load_use, exc_any, in_run, timeout;

    assign load_use = h_i_ex_ce & h_i_ex_load & (h_i_ex_rd != '0) &
                      ((h_i_ex_rd == h_i_de_rs1) | (h_i_ex_rd == h_i_de_rs2));
    assign in_run   = (state == ST_RUN);
    assign exc_any  = h_i_ex_exception[`ILLEGAL] | h_i_ex_exception[`ECALL] | h_i_ex_exception[`EBREAK];
    assign wcnt_inc = wcnt + 8'd1;
    assign timeout  = h_i_mem_busy & (wcnt_inc == 8'(MAX_MEM_WAIT));

    assign h_o_stall  = h_i_mem_busy | (in_run & load_use) | (state == ST_HALT);
    assign h_o_bubble = in_run & load_use & ~h_i_mem_busy;
    assign h_o_state  = state;
    assign h_o_halt   = (state == ST_HALT);

    always_comb begin
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        wcnt_nxt     = h_i_mem_busy ? wcnt_inc : 8'd0;
        flush_nxt    = h_o_flush;
        redir_nxt    = 1'b0;
        redir_pc_nxt = h_o_redirect_pc;
        mepc_nxt     = h_o_mepc;
        mcause_nxt   = h_o_mcause;
        case (state)
            ST_RUN: begin
                if (timeout) begin
                    state_nxt = ST_HALT;
                    flush_nxt = 1'b0;
                end else if (h_i_ex_ce && !h_i_mem_busy) begin
                    if (exc_any) begin
                        state_nxt    = ST_TRAP;
                        redir_pc_nxt = TRAP_VECTOR;
                        mepc_nxt     = h_i_ex_pc;
                        mcause_nxt   = h_i_ex_exception[`ILLEGAL] ? 2'd0 :
                                       h_i_ex_exception[`ECALL]   ? 2'd1 : 2'd2;
                    end else if (h_i_ex_exception[`MRET]) begin
                        state_nxt    = ST_FLUSH;
                        redir_pc_nxt = h_o_mepc;
                    end else if (h_i_ex_taken) begin
                        state_nxt    = ST_FLUSH;
                        redir_pc_nxt = h_i_ex_target;
                    end
                    if (state_nxt != ST_RUN) begin
                        redir_nxt = 1'b1;
                        flush_nxt = 1'b1;
                        fcnt_nxt  = 4'(FLUSH_CYCLES);
                    end
                end
            end
            ST_FLUSH, ST_TRAP: begin
                // Memory wait freezes the flush window; only the timeout can break out of it
                if (timeout) begin
                    state_nxt = ST_HALT;
                    flush_nxt = 1'b0;
                    fcnt_nxt  = 4'd0;
                end else if (!h_i_mem_busy) begin
                    if (fcnt <= 4'd1) begin
                        state_nxt = ST_RUN;
                        flush_nxt = 1'b0;
                        fcnt_nxt  = 4'd0;
                    end else begin
                        fcnt_nxt = fcnt - 4'd1;
                    end
                end
            end
            default: begin
                wcnt_nxt  = wcnt;
                flush_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            state           <= ST_RUN;
            fcnt            <= 4'd0;
            wcnt            <= 8'd0;
            h_o_flush       <= 1'b0;
            h_o_redirect    <= 1'b0;
            h_o_redirect_pc <= '0;
            h_o_mepc        <= '0;
            h_o_mcause      <= 2'd0;
        end else begin
            state           <= state_nxt;
            fcnt            <= fcnt_nxt;
            wcnt            <= wcnt_nxt;
            h_o_flush       <= flush_nxt;
            h_o_redirect    <= redir_nxt;
            h_o_redirect_pc <= redir_pc_nxt;
            h_o_mepc        <= mepc_nxt;
            h_o_mcause      <= mcause_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            h_o_stall_cnt <= 32'd0;
            h_o_flush_cnt <= 32'd0;
        end else begin
            h_o_stall_cnt <= h_o_stall_cnt + {31'd0, h_o_stall};
            h_o_flush_cnt <= h_o_flush_cnt + {31'd0, h_o_redirect};
        end
    end
`else
    assign h_o_stall_cnt = 32'd0;
    assign h_o_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: load-use, branch flush, trap/MRET, priority, memory wait, HALT, reset.
`timescale 1ns/1ps

module tb_hazard_ctrl;

    logic        h_clk = 1'b0;
    logic        h_rst;
    logic [4:0]  de_rs1, de_rs2, ex_rd;
    logic        ex_ce, ex_load, ex_taken, mem_busy;
    logic [31:0] ex_target, ex_pc;
    logic [3:0]  ex_exc;
    logic        stall, bubble, flush, redirect, halt;
    logic [31:0] redirect_pc, mepc, stall_cnt, flush_cnt;
    logic [1:0]  mcause, state;

    int vec = 0;
    int miscomp = 0;

    localparam logic [3:0] EXC_ILLEGAL = 4'b0001;
    localparam logic [3:0] EXC_ECALL   = 4'b0010;
    localparam logic [3:0] EXC_EBREAK  = 4'b0100;
    localparam logic [3:0] EXC_MRET    = 4'b1000;

    always #5 h_clk = ~h_clk;

    hazard_ctrl dut (
        .h_clk(h_clk), .h_rst(h_rst),
        .h_i_de_rs1(de_rs1), .h_i_de_rs2(de_rs2),
        .h_i_ex_ce(ex_ce), .h_i_ex_rd(ex_rd), .h_i_ex_load(ex_load),
        .h_i_ex_taken(ex_taken), .h_i_ex_target(ex_target), .h_i_ex_pc(ex_pc),
        .h_i_ex_exception(ex_exc), .h_i_mem_busy(mem_busy),
        .h_o_stall(stall), .h_o_bubble(bubble), .h_o_flush(flush),
        .h_o_redirect(redirect), .h_o_redirect_pc(redirect_pc),
        .h_o_mepc(mepc), .h_o_mcause(mcause), .h_o_state(state), .h_o_halt(halt),
        .h_o_stall_cnt(stall_cnt), .h_o_flush_cnt(flush_cnt)
    );

    task automatic tick();
        @(posedge h_clk);
        #1;
    endtask

    task automatic clear_inputs();
        de_rs1 = 0; de_rs2 = 0; ex_rd = 0; ex_ce = 0; ex_load = 0; ex_taken = 0;
        ex_target = 0; ex_pc = 0; ex_exc = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        h_rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        h_rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if ({stall, bubble, flush, redirect, halt} !== 5'b0) begin $display("FAIL reset_ctrl got %b want 00000", {stall, bubble, flush, redirect, halt}); miscomp++; end
        vec++; if (state !== 2'd0) begin $display("FAIL reset_state got %0d want 0", state); miscomp++; end
        vec++; if ({redirect_pc, mepc, mcause} !== 66'd0) begin $display("FAIL reset_regs got %h/%h/%0d want 0", redirect_pc, mepc, mcause); miscomp++; end
        vec++; if ({stall_cnt, flush_cnt} !== 64'd0) begin $display("FAIL reset_cnt got %0d/%0d want 0", stall_cnt, flush_cnt); miscomp++; end
    endtask

    task automatic test_load_use();
        ex_ce = 1; ex_load = 1; ex_rd = 5; de_rs1 = 5; de_rs2 = 7;
        #1;
        vec++; if ({stall, bubble} !== 2'b11) begin $display("FAIL lu_rs1 got %b want 11", {stall, bubble}); miscomp++; end
        tick();
        clear_inputs();
        #1;
        vec++; if ({stall, bubble} !== 2'b00) begin $display("FAIL lu_clear got %b want 00", {stall, bubble}); miscomp++; end
        vec++; if (state !== 2'd0) begin $display("FAIL lu_state got %0d want 0", state); miscomp++; end
        ex_ce = 1; ex_load = 1; ex_rd = 9; de_rs1 = 3; de_rs2 = 9;
        #1;
        vec++; if ({stall, bubble} !== 2'b11) begin $display("FAIL lu_rs2 got %b want 11", {stall, bubble}); miscomp++; end
        ex_rd = 0; de_rs1 = 0; de_rs2 = 0;
        #1;
        vec++; if ({stall, bubble} !== 2'b00) begin $display("FAIL lu_rd0 got %b want 00", {stall, bubble}); miscomp++; end
        ex_rd = 5; de_rs1 = 5; ex_load = 0;
        #1;
        vec++; if ({stall, bubble} !== 2'b00) begin $display("FAIL lu_noload got %b want 00", {stall, bubble}); miscomp++; end
        ex_load = 1; mem_busy = 1;
        #1;
        vec++; if ({stall, bubble} !== 2'b10) begin $display("FAIL lu_busy got %b want 10", {stall, bubble}); miscomp++; end
        clear_inputs();
        tick();
    endtask

    task automatic test_taken();
        ex_ce = 1; ex_taken = 1; ex_target = 32'h40;
        tick();
        // held event while flushing must be ignored
        ex_target = 32'h80;
        vec++; if ({redirect, flush} !== 2'b11) begin $display("FAIL br_c1 got %b want 11", {redirect, flush}); miscomp++; end
        vec++; if (redirect_pc !== 32'h40) begin $display("FAIL br_pc got %h want 00000040", redirect_pc); miscomp++; end
        vec++; if (state !== 2'd1) begin $display("FAIL br_state1 got %0d want 1", state); miscomp++; end
        tick();
        clear_inputs();
        vec++; if ({redirect, flush, state} !== 4'b0101) begin $display("FAIL br_c2 got %b want 0101", {redirect, flush, state}); miscomp++; end
        tick();
        vec++; if ({redirect, flush, state} !== 4'b0000) begin $display("FAIL br_c3 got %b want 0000", {redirect, flush, state}); miscomp++; end
    endtask

    task automatic test_trap_mret();
        ex_ce = 1; ex_exc = EXC_ECALL; ex_pc = 32'h24;
        tick();
        clear_inputs();
        vec++; if ({redirect, flush, state} !== 4'b1110) begin $display("FAIL ecall_ctrl got %b want 1110", {redirect, flush, state}); miscomp++; end
        vec++; if (redirect_pc !== 32'h100) begin $display("FAIL ecall_pc got %h want 00000100", redirect_pc); miscomp++; end
        vec++; if (mepc !== 32'h24) begin $display("FAIL ecall_mepc got %h want 00000024", mepc); miscomp++; end
        vec++; if (mcause !== 2'd1) begin $display("FAIL ecall_cause got %0d want 1", mcause); miscomp++; end
        tick();
        tick();
        vec++; if ({flush, state} !== 3'b000) begin $display("FAIL ecall_end got %b want 000", {flush, state}); miscomp++; end
        ex_ce = 1; ex_exc = EXC_MRET; ex_pc = 32'h200;
        tick();
        clear_inputs();
        vec++; if ({redirect, state} !== 3'b101) begin $display("FAIL mret_ctrl got %b want 101", {redirect, state}); miscomp++; end
        vec++; if (redirect_pc !== 32'h24) begin $display("FAIL mret_pc got %h want 00000024", redirect_pc); miscomp++; end
        tick();
        tick();
    endtask

    task automatic test_priority();
        ex_ce = 1; ex_exc = EXC_ILLEGAL; ex_taken = 1; ex_target = 32'h40; ex_pc = 32'h30;
        tick();
        clear_inputs();
        vec++; if (redirect_pc !== 32'h100) begin $display("FAIL prio_pc got %h want 00000100", redirect_pc); miscomp++; end
        vec++; if ({mcause, state} !== 4'b0010) begin $display("FAIL prio_cause got %b want 0010", {mcause, state}); miscomp++; end
        vec++; if (mepc !== 32'h30) begin $display("FAIL prio_mepc got %h want 00000030", mepc); miscomp++; end
        tick();
        tick();
        ex_ce = 1; ex_exc = EXC_EBREAK | EXC_MRET; ex_pc = 32'h44;
        tick();
        clear_inputs();
        vec++; if ({mcause, state, redirect_pc} !== {2'd2, 2'd2, 32'h100}) begin $display("FAIL ebreak_prio got %0d/%0d/%h want 2/2/00000100", mcause, state, redirect_pc); miscomp++; end
        tick();
        tick();
        ex_taken = 1; ex_target = 32'h60;
        tick();
        clear_inputs();
        vec++; if (redirect !== 1'b0) begin $display("FAIL no_ce got %b want 0", redirect); miscomp++; end
    endtask

    task automatic test_busy_flush();
        ex_ce = 1; ex_taken = 1; ex_target = 32'h40;
        tick();
        clear_inputs();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++; if ({redirect, flush, state} !== 4'b0101) begin $display("FAIL busy_frz%0d got %b want 0101", i, {redirect, flush, state}); miscomp++; end
        end
        mem_busy = 0;
        tick();
        vec++; if ({flush, state} !== 3'b101) begin $display("FAIL busy_c5 got %b want 101", {flush, state}); miscomp++; end
        tick();
        vec++; if ({flush, state} !== 3'b000) begin $display("FAIL busy_c6 got %b want 000", {flush, state}); miscomp++; end
    endtask

    task automatic test_halt();
        ex_ce = 1; ex_taken = 1; ex_target = 32'h40;
        tick();
        clear_inputs();
        mem_busy = 1;
        for (int i = 0; i < 14; i++) tick();
        vec++; if ({halt, flush, state} !== 4'b0101) begin $display("FAIL halt_pre got %b want 0101", {halt, flush, state}); miscomp++; end
        tick();
        vec++; if ({halt, flush, state, stall} !== 5'b10111) begin $display("FAIL halt_in got %b want 10111", {halt, flush, state, stall}); miscomp++; end
        mem_busy = 0; ex_ce = 1; ex_taken = 1;
        tick();
        tick();
        clear_inputs();
        #1;
        vec++; if ({halt, stall, state, redirect} !== 5'b11110) begin $display("FAIL halt_hold got %b want 11110", {halt, stall, state, redirect}); miscomp++; end
        do_reset();
        vec++; if ({halt, stall, state} !== 4'b0000) begin $display("FAIL halt_exit got %b want 0000", {halt, stall, state}); miscomp++; end
    endtask

    task automatic test_reset_mid_trap();
        ex_ce = 1; ex_exc = EXC_ECALL; ex_pc = 32'h24;
        tick();
        clear_inputs();
        vec++; if (state !== 2'd2) begin $display("FAIL rst_pre got %0d want 2", state); miscomp++; end
        #2;
        h_rst = 0;
        #1;
        vec++; if ({flush, redirect, state, mcause} !== 6'd0 || mepc !== 32'd0 || redirect_pc !== 32'd0) begin $display("FAIL rst_async got %b/%h/%h want 0", {flush, redirect, state, mcause}, mepc, redirect_pc); miscomp++; end
        @(negedge h_clk);
        h_rst = 1;
        tick();
        vec++; if ({flush, redirect, state, stall, halt} !== 6'd0) begin $display("FAIL rst_after got %b want 000000", {flush, redirect, state, stall, halt}); miscomp++; end
`ifndef HAZARD_PERF_EN
        vec++; if ({stall_cnt, flush_cnt} !== 64'd0) begin $display("FAIL perf_off got %0d/%0d want 0", stall_cnt, flush_cnt); miscomp++; end
`endif
    endtask

    initial begin
        h_rst = 0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_taken();
        test_trap_mret();
        test_priority();
        test_busy_flush();
        test_halt();
        test_reset_mid_trap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
        $finish;
    end

endmodule
